// File: rtl/fence_sequencer_if.sv
// fence_sequencer_if: handshake bundle between the execute stage / cache control and the
// FENCE.I sequencer.
//   ifence        execute-stage FENCE.I decode, level
//   dflush_done   dcache flush complete, 1-cycle pulse
//   iflush_done   icache flush complete, 1-cycle pulse
//   dcache_flush  dcache flush request, 1-cycle pulse
//   icache_flush  icache flush request, 1-cycle pulse
//   fence_stall   stall to the hazard unit
//   fence_done    sequence complete, 1-cycle pulse
//   timeout_err   sticky watchdog expiry flag
// Modports: master = pipeline/cache side, slave = sequencer.
`timescale 1ns/1ps

interface fence_sequencer_if;
  logic ifence;
  logic dflush_done;
  logic iflush_done;
  logic dcache_flush;
  logic icache_flush;
  logic fence_stall;
  logic fence_done;
  logic timeout_err;

  modport master (
    output ifence,
    output dflush_done,
    output iflush_done,
    input  dcache_flush,
    input  icache_flush,
    input  fence_stall,
    input  fence_done,
    input  timeout_err
  );

  modport slave (
    input  ifence,
    input  dflush_done,
    input  iflush_done,
    output dcache_flush,
    output icache_flush,
    output fence_stall,
    output fence_done,
    output timeout_err
  );
endinterface

// File: rtl/fence_sequencer.sv
// fence_sequencer: orders FENCE.I cache maintenance. A dcache flush is requested and completed
// strictly before the icache flush; the pipeline is stalled until both finish and fence_done
// pulses once per fence instruction. An optional per-phase watchdog forces a stuck phase to
// complete and records the event in a sticky timeout_err.
// Ports:
//   CLK   clock
//   nRST  synchronous active-low reset
//   fif   fence_sequencer_if.slave (ifence, *_done inputs; flush requests, stall, done, error)
// Parameters:
//   DCACHE_PRESENT  0 skips the dcache phase
//   ICACHE_PRESENT  0 skips the icache phase
//   TIMEOUT_CYCLES  watchdog limit per wait phase (1..65535), 0 disables it
`timescale 1ns/1ps

module fence_sequencer #(
  parameter bit          DCACHE_PRESENT = 1'b1,
  parameter bit          ICACHE_PRESENT = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input logic              CLK,
  input logic              nRST,
  fence_sequencer_if.slave fif
);

  typedef enum logic [2:0] {
    StIdle,
    StDReq,
    StDWait,
    StIReq,
    StIWait,
    StDone,
    StHold
  } state_e;

  localparam bit          WdogEn    = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WdogLimit = 16'(TIMEOUT_CYCLES - 1);

  // Phase entered from IDLE, and phase following the dcache phase, with absent caches skipped.
  localparam state_e FirstState = DCACHE_PRESENT ? StDReq :
                                  (ICACHE_PRESENT ? StIReq : StDone);
  localparam state_e AfterD     = ICACHE_PRESENT ? StIReq : StDone;

  state_e      state_q, state_d;
  logic [15:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;
  logic        dflush_q, iflush_q, done_q;
  logic        wdog_expire;

  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    timeout_d   = timeout_q;
    wdog_expire = WdogEn && (wdog_q == WdogLimit);

    unique case (state_q)
      StIdle: begin
        if (fif.ifence) state_d = FirstState;
      end
      StDReq, StDWait: begin
        // A real done wins over a coincident expiry, so no error is flagged then.
        if (fif.dflush_done) begin
          state_d = AfterD;
        end else if (wdog_expire) begin
          state_d   = AfterD;
          timeout_d = 1'b1;
        end else begin
          state_d = StDWait;
          wdog_d  = wdog_q + 16'd1;
        end
      end
      StIReq, StIWait: begin
        if (fif.iflush_done) begin
          state_d = StDone;
        end else if (wdog_expire) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end else begin
          state_d = StIWait;
          wdog_d  = wdog_q + 16'd1;
        end
      end
      StDone: begin
        // Still-held ifence means the same instruction; park in HOLD so it cannot retrigger.
        state_d = fif.ifence ? StHold : StIdle;
      end
      StHold: begin
        if (!fif.ifence) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // REQ states last exactly one cycle, so being the next state means a fresh phase entry.
    if (state_d == StDReq || state_d == StIReq) wdog_d = '0;
  end

  // State plus Moore outputs registered from the next state, so they line up with state_q.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= StIdle;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
      dflush_q  <= 1'b0;
      iflush_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
      dflush_q  <= (state_d == StDReq);
      iflush_q  <= (state_d == StIReq);
      done_q    <= (state_d == StDone);
    end
  end

  assign fif.dcache_flush = dflush_q;
  assign fif.icache_flush = iflush_q;
  assign fif.fence_done   = done_q;
  assign fif.timeout_err  = timeout_q;
  // Combinational so the IDLE cycle that first sees ifence is already stalled.
  assign fif.fence_stall  = fif.ifence && !(state_q inside {StDone, StHold});

endmodule

// File: tb/tb_fence_sequencer.sv
`timescale 1ns/1ps

module tb_fence_sequencer;

  localparam int MAXN  = 64;
  localparam int NEVER = 100000;

  logic CLK = 1'b0;
  logic nRST;
  logic ifence, dd, id;

  always #5 CLK = ~CLK;

  // Three configurations share one stimulus stream; each has its own expected slice.
  // u0: both caches, no watchdog. u1: both caches, TIMEOUT_CYCLES=4. u2: no dcache.
  fence_sequencer_if if0 ();
  fence_sequencer_if if1 ();
  fence_sequencer_if if2 ();

  assign if0.ifence = ifence;  assign if0.dflush_done = dd;  assign if0.iflush_done = id;
  assign if1.ifence = ifence;  assign if1.dflush_done = dd;  assign if1.iflush_done = id;
  assign if2.ifence = ifence;  assign if2.dflush_done = dd;  assign if2.iflush_done = id;

  fence_sequencer #(.DCACHE_PRESENT(1'b1), .ICACHE_PRESENT(1'b1), .TIMEOUT_CYCLES(0))
    u0 (.CLK(CLK), .nRST(nRST), .fif(if0));
  fence_sequencer #(.DCACHE_PRESENT(1'b1), .ICACHE_PRESENT(1'b1), .TIMEOUT_CYCLES(4))
    u1 (.CLK(CLK), .nRST(nRST), .fif(if1));
  fence_sequencer #(.DCACHE_PRESENT(1'b0), .ICACHE_PRESENT(1'b1), .TIMEOUT_CYCLES(0))
    u2 (.CLK(CLK), .nRST(nRST), .fif(if2));

  // Per-cycle stimulus and observations. Vector per config: {dflush, iflush, stall, done, err}
  // packed u0 in [14:10], u1 in [9:5], u2 in [4:0].
  bit          ifv [MAXN];
  bit          ddv [MAXN];
  bit          idv [MAXN];
  logic [14:0] obs [MAXN];
  logic [14:0] expv[MAXN];

  int checks;
  int errors;

  function automatic logic [14:0] sample_all();
    return {if0.dcache_flush, if0.icache_flush, if0.fence_stall, if0.fence_done, if0.timeout_err,
            if1.dcache_flush, if1.icache_flush, if1.fence_stall, if1.fence_done, if1.timeout_err,
            if2.dcache_flush, if2.icache_flush, if2.fence_stall, if2.fence_done, if2.timeout_err};
  endfunction

  // Cycle at which a phase requested at 'req' completes: the first matching done pulse at or
  // after the request, or the watchdog after tmo cycles in the phase.
  function automatic int find_exit(input bit use_d, input int req, input int tmo, output bit to);
    to = 1'b0;
    for (int c = req; c < MAXN; c++) begin
      if (use_d ? ddv[c] : idv[c]) return c;
      if (tmo != 0 && (c - req) == tmo - 1) begin
        to = 1'b1;
        return c;
      end
    end
    return NEVER;
  endfunction

  // Reference schedule for one config; ifence is assumed to rise at cycle 0 straight from reset
  // and, once dropped, to stay low for the rest of the window.
  function automatic void model_cfg(input int k, input bit dp, input bit ip, input int tmo,
                                    input int n);
    int t, rd, ri, ex, err_from, done_c;
    bit to;
    t = 1; rd = -1; ri = -1; err_from = NEVER * 4;
    if (dp) begin
      rd = t;
      ex = find_exit(1'b1, rd, tmo, to);
      if (to) err_from = ex + 1;
      t = ex + 1;
    end
    if (ip) begin
      ri = t;
      ex = find_exit(1'b0, ri, tmo, to);
      if (to && ex + 1 < err_from) err_from = ex + 1;
      t = ex + 1;
    end
    done_c = t;
    for (int c = 0; c < n; c++) begin
      expv[c][(2-k)*5 +: 5] = {c == rd, c == ri, ifv[c] && (c < done_c), c == done_c,
                               c >= err_from};
    end
  endfunction

  function automatic void build_model(input int n);
    model_cfg(0, 1'b1, 1'b1, 0, n);
    model_cfg(1, 1'b1, 1'b1, 4, n);
    model_cfg(2, 1'b0, 1'b1, 0, n);
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < MAXN; c++) begin
      ifv[c] = 1'b0; ddv[c] = 1'b0; idv[c] = 1'b0;
      obs[c] = '0;   expv[c] = '0;
    end
  endtask

  // One reset cycle, then n cycles of stimulus; observations recorded on the falling edge.
  task automatic run_window(input int n);
    build_model(n);
    nRST = 1'b0; ifence = 1'b0; dd = 1'b0; id = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    for (int c = 0; c < n; c++) begin
      ifence = ifv[c]; dd = ddv[c]; id = idv[c];
      @(negedge CLK);
      obs[c] = sample_all();
      @(posedge CLK); #1;
    end
    ifence = 1'b0; dd = 1'b0; id = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] got;
    nRST = 1'b0; ifence = 1'b0; dd = 1'b0; id = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    got = sample_all();
    checks++;
    if (got !== 15'b0) begin
      errors++; $display("FAIL reset_idle got=%b want=%b", got, 15'b0);
    end
    ifence = 1'b1;
    #1;
    got = sample_all();
    checks++;
    if (got !== {3{5'b00100}}) begin
      errors++; $display("FAIL reset_stall got=%b want=%b", got, {3{5'b00100}});
    end
    ifence = 1'b0;
  endtask

  task automatic test_nominal();
    clear_stim();
    for (int c = 0; c < 14; c++) ifv[c] = 1'b1;
    ddv[4] = 1'b1; idv[8] = 1'b1;
    run_window(18);
    for (int c = 0; c < 18; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++; $display("FAIL nominal cyc=%0d got=%b want=%b", c, obs[c], expv[c]);
      end
    end
    checks++;
    if (obs[9][11] !== 1'b1) begin
      errors++; $display("FAIL nominal_done9 got=%b want=1", obs[9][11]);
    end
  endtask

  task automatic test_zero_latency();
    clear_stim();
    for (int c = 0; c < 6; c++) ifv[c] = 1'b1;
    ddv[1] = 1'b1; idv[2] = 1'b1;
    run_window(10);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++; $display("FAIL zero_latency cyc=%0d got=%b want=%b", c, obs[c], expv[c]);
      end
    end
  endtask

  task automatic test_stray();
    clear_stim();
    for (int c = 0; c < 16; c++) ifv[c] = 1'b1;
    idv[2] = 1'b1; ddv[6] = 1'b1; idv[11] = 1'b1;
    run_window(20);
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++; $display("FAIL stray cyc=%0d got=%b want=%b", c, obs[c], expv[c]);
      end
    end
    checks++;
    if (obs[7][13] !== 1'b1) begin
      errors++; $display("FAIL stray_iflush7 got=%b want=1", obs[7][13]);
    end
  endtask

  task automatic test_watchdog();
    clear_stim();
    for (int c = 0; c < 20; c++) ifv[c] = 1'b1;
    idv[9] = 1'b1;
    run_window(24);
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++; $display("FAIL watchdog cyc=%0d got=%b want=%b", c, obs[c], expv[c]);
      end
    end
    checks++;
    if (obs[5][8] !== 1'b1 || obs[23][5] !== 1'b1) begin
      errors++;
      $display("FAIL watchdog_u1 iflush5=%b err23=%b want=1,1", obs[5][8], obs[23][5]);
    end
  endtask

  task automatic test_squash();
    clear_stim();
    for (int c = 0; c < 3; c++) ifv[c] = 1'b1;
    ddv[5] = 1'b1; idv[8] = 1'b1;
    run_window(14);
    for (int c = 0; c < 14; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++; $display("FAIL squash cyc=%0d got=%b want=%b", c, obs[c], expv[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    // u0 is left in I_WAIT; the next window's leading reset abandons it.
    clear_stim();
    for (int c = 0; c < 20; c++) ifv[c] = 1'b1;
    ddv[3] = 1'b1;
    run_window(10);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++; $display("FAIL reset_mid_pre cyc=%0d got=%b want=%b", c, obs[c], expv[c]);
      end
    end
    clear_stim();
    for (int c = 0; c < 6; c++) ifv[c] = 1'b1;
    ddv[1] = 1'b1; idv[2] = 1'b1;
    run_window(8);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++; $display("FAIL reset_mid_post cyc=%0d got=%b want=%b", c, obs[c], expv[c]);
      end
    end
    checks++;
    if (obs[1][14] !== 1'b1 || obs[1][3] !== 1'b1) begin
      errors++;
      $display("FAIL restart u0_dflush1=%b u2_iflush1=%b want=1,1", obs[1][14], obs[1][3]);
    end
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 20; it++) begin
      clear_stim();
      len = $urandom_range(1, 30);
      for (int c = 0; c < 40; c++) begin
        ifv[c] = (c < len);
        ddv[c] = ($urandom_range(0, 5) == 0);
        idv[c] = ($urandom_range(0, 5) == 0);
      end
      run_window(40);
      for (int c = 0; c < 40; c++) begin
        checks++;
        if (obs[c] !== expv[c]) begin
          errors++;
          $display("FAIL random it=%0d cyc=%0d got=%b want=%b", it, c, obs[c], expv[c]);
        end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    nRST = 1'b0; ifence = 1'b0; dd = 1'b0; id = 1'b0;
    test_reset();
    test_nominal();
    test_zero_latency();
    test_stray();
    test_watchdog();
    test_squash();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
